// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory responder.
// MMIO offsets, STATUS bit positions and reset values.
package dmem_pkg;

  localparam logic [15:0] MMIO_LED    = 16'h0000;
  localparam logic [15:0] MMIO_SW     = 16'h0004;
  localparam logic [15:0] MMIO_TIMER  = 16'h0008;
  localparam logic [15:0] MMIO_CMP    = 16'h000C;
  localparam logic [15:0] MMIO_STATUS = 16'h0010;

  localparam int ST_MATCH  = 0;
  localparam int ST_IRQ_EN = 1;

  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// Word-organised, byte-writable RAM with read-first registered output.
// Contents and output register are not reset.
module dmem_ram_bank #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: RAM bank plus LED/switch/timer MMIO window.
// One-cycle read latency, read-first on writes.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] MMIO_BASE  = 32'hBFAF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Mem_en,
  input  logic [3:0]  Mem_write_en,
  input  logic [31:0] Mem_addr,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        timer_irq
);

  logic        is_mmio;
  logic        mmio_wr;
  logic [15:0] off;
  logic        hit_led, hit_sw, hit_tmr;
  logic        hit_cmp, hit_st;

  logic [15:0] led_q, led_d;
  logic [15:0] sw_s1, sw_s2;
  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q, cmp_d;
  logic        match_q, match_d;
  logic        irq_en_q, irq_en_d;
  logic        irq_q;
  logic        st_wr, w1c;

  logic        rd_vld_q, sel_mmio_q;
  logic [31:0] mmio_rd, mmio_rd_q;
  logic [31:0] ram_rd;
  logic        unused_ok;

  assign is_mmio = Mem_addr[31:16] == MMIO_BASE[31:16];
  assign off     = {Mem_addr[15:2], 2'b00};
  assign mmio_wr = Mem_en && is_mmio
                && (Mem_write_en != 4'b0000);

  assign hit_led = off == MMIO_LED;
  assign hit_sw  = off == MMIO_SW;
  assign hit_tmr = off == MMIO_TIMER;
  assign hit_cmp = off == MMIO_CMP;
  assign hit_st  = off == MMIO_STATUS;

  assign unused_ok = &{1'b0, Mem_addr[1:0]};

  dmem_ram_bank #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (Mem_en && !is_mmio),
    .we    (Mem_write_en),
    .addr  (Mem_addr[ADDR_WIDTH+1:2]),
    .wdata (Write_data),
    .rdata (ram_rd)
  );

  always_comb begin
    mmio_rd = '0;
    unique case (1'b1)
      hit_led: mmio_rd = {16'h0, led_q};
      hit_sw:  mmio_rd = {16'h0, sw_s2};
      hit_tmr: mmio_rd = timer_q;
      hit_cmp: mmio_rd = cmp_q;
      hit_st:  mmio_rd = {30'h0, irq_en_q, match_q};
      default: mmio_rd = '0;
    endcase
  end

  // A CPU write to TIMER replaces that cycle's increment.
  always_comb begin
    led_d    = led_q;
    timer_d  = timer_q + 32'd1;
    cmp_d    = cmp_q;
    irq_en_d = irq_en_q;
    st_wr    = mmio_wr && hit_st && Mem_write_en[0];
    w1c      = st_wr && Write_data[ST_MATCH];
    if (mmio_wr && hit_led) begin
      if (Mem_write_en[0]) led_d[7:0]  = Write_data[7:0];
      if (Mem_write_en[1]) led_d[15:8] = Write_data[15:8];
    end
    if (mmio_wr && hit_tmr)
      timer_d = byte_merge(timer_q, Write_data, Mem_write_en);
    if (mmio_wr && hit_cmp)
      cmp_d = byte_merge(cmp_q, Write_data, Mem_write_en);
    if (st_wr)
      irq_en_d = Write_data[ST_IRQ_EN];
    match_d = (timer_q == cmp_q) || (match_q && !w1c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q      <= '0;
      sw_s1      <= '0;
      sw_s2      <= '0;
      timer_q    <= '0;
      cmp_q      <= CMP_RST;
      match_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      rd_vld_q   <= 1'b0;
      sel_mmio_q <= 1'b0;
      mmio_rd_q  <= '0;
    end else begin
      led_q    <= led_d;
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
      timer_q  <= timer_d;
      cmp_q    <= cmp_d;
      match_q  <= match_d;
      irq_en_q <= irq_en_d;
      irq_q    <= match_d && irq_en_d;
      if (Mem_en) begin
        rd_vld_q   <= 1'b1;
        sel_mmio_q <= is_mmio;
        mmio_rd_q  <= mmio_rd;
      end
    end
  end

  // RAM output is unreset, so gate it until a post-reset request lands.
  assign Read_data = !rd_vld_q  ? 32'h0 :
                     sel_mmio_q ? mmio_rd_q : ram_rd;
  assign led       = led_q;
  assign timer_irq = irq_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder.
// Reference model tracks RAM words and MMIO registers per cycle.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Mem_en = 1'b0;
  logic [3:0]  Mem_write_en = '0;
  logic [31:0] Mem_addr = '0;
  logic [31:0] Write_data = '0;
  logic [31:0] Read_data;
  logic [15:0] sw = '0;
  logic [15:0] led;
  logic        timer_irq;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [31:0] BASE = 32'hBFAF_0000;

  dmem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .Mem_en       (Mem_en),
    .Mem_write_en (Mem_write_en),
    .Mem_addr     (Mem_addr),
    .Write_data   (Write_data),
    .Read_data    (Read_data),
    .sw           (sw),
    .led          (led),
    .timer_irq    (timer_irq)
  );

  always #5 clk = ~clk;

  logic [31:0] m_ram [4096];
  logic [31:0] m_rd, m_timer, m_cmp;
  logic [15:0] m_led, m_s1, m_s2;
  logic        m_match, m_en, m_irq;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o,
                                      input logic [31:0] w,
                                      input logic [3:0]  s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[i*8 +: 8] = w[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [15:0] o);
    case (o)
      16'h0000: return {16'h0, m_led};
      16'h0004: return {16'h0, m_s2};
      16'h0008: return m_timer;
      16'h000C: return m_cmp;
      16'h0010: return {30'h0, m_en, m_match};
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_rd = 0; m_led = 0; m_timer = 0;
    m_cmp = 32'hFFFF_FFFF;
    m_match = 0; m_en = 0; m_irq = 0;
    m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_edge(input logic en, input logic [3:0] we,
                            input logic [31:0] a, input logic [31:0] wd);
    bit          mm, w, hit, clr;
    logic [15:0] o;
    logic [31:0] t, nt;
    int          idx;
    mm  = a[31:16] == 16'hBFAF;
    o   = {a[15:2], 2'b00};
    idx = int'(a[13:2]);
    w   = en && we != 0;
    hit = m_timer == m_cmp;
    nt  = m_timer + 1;
    clr = 0;
    if (en) m_rd = mm ? mread(o) : m_ram[idx];
    if (w && !mm) m_ram[idx] = mrg(m_ram[idx], wd, we);
    if (w && mm) begin
      case (o)
        16'h0000: begin
          t = mrg({16'h0, m_led}, wd, we);
          m_led = t[15:0];
        end
        16'h0008: nt = mrg(m_timer, wd, we);
        16'h000C: m_cmp = mrg(m_cmp, wd, we);
        16'h0010: if (we[0]) begin
          clr  = wd[0];
          m_en = wd[1];
        end
        default: ;
      endcase
    end
    m_timer = nt;
    m_match = hit || (m_match && !clr);
    m_irq   = m_match && m_en;
    m_s2    = m_s1;
    m_s1    = sw;
  endtask

  task automatic cyc(input logic en, input logic [3:0] we,
                     input logic [31:0] a, input logic [31:0] wd);
    Mem_en = en; Mem_write_en = we;
    Mem_addr = a; Write_data = wd;
    @(posedge clk);
    model_edge(en, we, a, wd);
    #1;
    chk("rdata", Read_data, m_rd);
    chk("led", {16'h0, led}, {16'h0, m_led});
    chk("irq", {31'h0, timer_irq}, {31'h0, m_irq});
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    bit          saw;
    logic [31:0] a;
    logic [3:0]  we;
    int          k;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_rdata", Read_data, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_irq", {31'h0, timer_irq}, 32'h0);
    cyc(1, 0, BASE + 32'hC, 0);
    chk("rst_cmp", Read_data, 32'hFFFF_FFFF);
    cyc(1, 0, BASE + 32'h10, 0);
    chk("rst_status", Read_data, 32'h0);

    for (int i = 0; i < 17; i++) cyc(1, 4'hF, i * 4, $urandom);

    cyc(1, 4'hF, 32'h40, 32'h1122_3344);
    cyc(1, 4'h2, 32'h40, 32'hAABB_CCDD);
    cyc(1, 4'h0, 32'h40, 0);
    chk("ram_byte", Read_data, 32'h1122_CC44);

    cyc(1, 4'hF, 32'h4000, 32'hDEAD_BEEF);
    cyc(1, 4'hF, 32'h0, 32'h1);
    chk("alias_rf", Read_data, 32'hDEAD_BEEF);
    cyc(1, 4'h0, 32'h0, 0);
    chk("wr_then_rd", Read_data, 32'h1);

    cyc(1, 4'hF, BASE, 32'h0001_A5A5);
    chk("led_out", {16'h0, led}, 32'hA5A5);
    cyc(1, 4'h0, BASE, 0);
    chk("led_rd", Read_data, 32'h0000_A5A5);

    sw = 16'h1234;
    idle();
    idle();
    cyc(1, 4'h0, BASE + 4, 0);
    chk("sw_sync", Read_data, 32'h0000_1234);

    cyc(1, 4'hF, BASE + 32'hC, 32'd20);
    cyc(1, 4'hF, BASE + 32'h10, 32'h3);
    cyc(1, 4'hF, BASE + 8, 32'h0);
    saw = 0;
    for (int i = 0; i < 40 && !saw; i++) begin
      idle();
      saw = timer_irq;
    end
    chk("irq_rise", {31'h0, saw}, 32'h1);
    cyc(1, 4'hF, BASE + 32'h10, 32'h1);
    chk("irq_fall", {31'h0, timer_irq}, 32'h0);

    cyc(1, 4'hF, BASE + 8, 32'hFFFF_FFFE);
    cyc(1, 4'h0, BASE + 8, 0);
    chk("tmr_fe", Read_data, 32'hFFFF_FFFE);
    cyc(1, 4'h0, BASE + 8, 0);
    cyc(1, 4'h0, BASE + 8, 0);
    chk("tmr_wrap", Read_data, 32'h0);

    cyc(1, 4'hF, BASE + 8, 32'd50);
    cyc(1, 4'hF, BASE + 32'hC, 32'd53);
    cyc(1, 4'hF, BASE + 32'h10, 32'h1);
    idle();
    cyc(1, 4'hF, BASE + 32'h10, 32'h1);
    cyc(1, 4'h0, BASE + 32'h10, 0);
    chk("set_wins", {31'h0, Read_data[0]}, 32'h1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) sw = 16'($urandom);
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 6);
        a = BASE + ((k < 5) ? k * 4 : (k == 5 ? 32'h14 : 32'h40));
        a = a | 32'($urandom_range(0, 3));
      end else begin
        a = (32'($urandom_range(0, 15)) << 2)
          | (32'($urandom_range(0, 7)) << 14)
          | 32'($urandom_range(0, 3));
      end
      cyc(1'($urandom_range(0, 3) != 0), we, a, $urandom);
    end

    cyc(1, 4'hF, BASE, 32'h0000_5A5A);
    cyc(1, 4'h0, BASE, 0);
    chk("pre_rst", Read_data, 32'h0000_5A5A);
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_rd", Read_data, 32'h0);
    chk("mid_rst_led", {16'h0, led}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    Mem_en = 1'b0;
    idle();
    chk("post_rst_rd", Read_data, 32'h0);
    cyc(1, 4'h0, BASE + 8, 0);
    cyc(1, 4'h0, BASE + 8, 0);
    chk("tmr_restart", Read_data, 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder side of the CPU data-memory port: accepts the core's synchronous SRAM-style requests (enable, per-byte write strobes, byte address, write data) and returns read data one cycle later. It contains a word-organised, byte-writable RAM plus a small memory-mapped peripheral window: LEDs, synchronised switches, and a free-running timer with compare interrupt. It sits directly beside the core at SoC top level, on the data side.

## Interface
- `ADDR_WIDTH`, 12: RAM word-address width (4096 words, 16 KiB).
- `MMIO_BASE`, 32'hBFAF_0000: base of the 64 KiB peripheral window; only bits [31:16] are compared.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `Mem_en` in 1: request valid this cycle.
- `Mem_write_en` in 4: byte-lane write strobes. Nonzero means write; zero with `Mem_en` means read.
- `Mem_addr` in 32: byte address. Bits [1:0] are ignored (word access).
- `Write_data` in 32: write data. Lane i is bits [8i+7:8i].
- `Read_data` out 32: read data for the request of the previous cycle.
- `sw` in 16: asynchronous board switches.
- `led` out 16: LED register.
- `timer_irq` out 1: timer interrupt, level-sensitive.

## Operation
- Decode: an address is MMIO if `Mem_addr[31:16] == MMIO_BASE[31:16]`. Otherwise it is RAM.
- RAM index is `Mem_addr[ADDR_WIDTH+1:2]`. Upper bits are ignored, so addresses alias (wrap) modulo the RAM size.
- Every accepted request updates `Read_data` on the next edge. This includes writes, which return the pre-write word (read-first).
- With `Mem_en`=0, `Read_data` holds its last value.
- RAM write: only lanes whose strobe is set are updated.
- MMIO map (offset from base):
  - 0x00 LED: RW, bits [15:0]. Upper bits read 0.
  - 0x04 SWITCH: RO. Value of `sw` after a 2-flop synchroniser, zero-extended. Writes are ignored.
  - 0x08 TIMER: RW. Increments by 1 every cycle and wraps from FFFF_FFFF to 0.
  - 0x0C COMPARE: RW.
  - 0x10 STATUS: bit0 MATCH is sticky and write-1-to-clear; bit1 IRQ_EN is RW; other bits read 0.
- All other MMIO offsets read 0, and writes to them are ignored.
- MMIO writes honour byte strobes per lane, like RAM.
- MATCH sets on the cycle the current TIMER value equals COMPARE.
- `timer_irq` = MATCH & IRQ_EN, driven from flops.
- Simultaneous events:
  - CPU write to TIMER vs increment: the written lanes take the written value; the increment resumes next cycle.
  - MATCH set and W1C clear in the same cycle: set wins.
  - Read of TIMER returns the value before that cycle's increment.

## Timing
- Read latency is exactly 1 cycle. There are no wait states and no stall output; a new request is accepted every cycle.
- Back-to-back write then read of the same word: the read returns the newly written data (the write landed on the earlier edge).
- Values on reset assertion:
  - `Read_data` = 0, LED = 0, `led` = 0.
  - TIMER = 0, COMPARE = FFFF_FFFF, STATUS = 0, `timer_irq` = 0.
  - Synchroniser flops = 0.
- RAM contents are not reset.
- Reset asserted mid-request: the in-flight read is discarded and `Read_data` = 0 until the first post-reset request completes.
- TIMER starts counting on the first edge after `rst` deasserts.
- The SWITCH register reflects a `sw` change 2 edges after it is sampled, so a read observes it on the 3rd cycle.

## Structure
- Shared package `dmem_pkg`:
  - MMIO offset constants (`MMIO_LED`, `MMIO_SW`, `MMIO_TIMER`, `MMIO_CMP`, `MMIO_STATUS`).
  - STATUS bit indices.
  - Reset constants (`CMP_RST` = 32'hFFFF_FFFF).
- Sub-module `dmem_ram_bank`:
  - Parameter `ADDR_WIDTH`; 4 byte lanes.
  - Synchronous read-first, registered output.
  - Not reset; inferable as block RAM.
- The top-level block holds decode, the registered MMIO/RAM select for the output mux, peripheral registers, synchroniser and timer.

## Test plan
- **RAM byte write:** write 0x11223344 with strobe 1111 to 0x0000_0040, then strobe 0010 with 0xAABBCCDD to the same address, then read → `Read_data` = 0x1122CC44 one cycle after the read.
- **Aliasing and read-first:** write 0xDEADBEEF to 0x0000_4000 (aliases word 0). Next, issue a write of 0x1 to word 0 → that cycle's `Read_data` = 0xDEADBEEF.
- **LED and switches:**
  - Write 0x0001A5A5 to 0xBFAF_0000 → `led` = 0xA5A5; reading it back gives 0x0000A5A5.
  - Drive `sw` = 0x1234 and read 0xBFAF_0004 three cycles later → 0x00001234.
- **Timer compare:**
  - Write COMPARE = 20, STATUS = 0x2, TIMER = 0 → `timer_irq` rises when TIMER passes 20.
  - Write STATUS = 0x1 → `timer_irq` falls the next cycle.
  - TIMER = FFFF_FFFE → wraps to 0 two cycles later.
- **Simultaneous set/clear:** W1C write to STATUS in the exact match cycle → MATCH remains 1.
- **Reset mid-read:** assert `rst` the cycle after a read of nonzero data → `Read_data` = 0 immediately (asynchronously); TIMER = 0 and `led` = 0.
